vend_dispense_scheduler: RTL and testbench

Shared-resource scheduler for a two-panel vending machine. Two vending cores (one per customer panel) share a single dispense motor and a single coin-return unit; this block arbitrates their vend requests round-robin, checks per-product stock, runs the motor for a fixed time, and pays out change or a full refund. It sits between the per-panel vending cores and the mechanism drivers.

---
 rtl/vend_dispense_scheduler_if.sv | 31 +++
 rtl/vend_dispense_scheduler.sv | 159 +++++++++++++++
 tb/tb_vend_dispense_scheduler.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/vend_dispense_scheduler_if.sv
// Panel-side and mechanism-side signal bundle for the dispense scheduler.
interface vend_dispense_scheduler_if;
  logic [1:0] req;
  logic [2:0] p0;
  logic [2:0] p1;
  logic [2:0] chg0;
  logic [2:0] chg1;
  logic [2:0] paid0;
  logic [2:0] paid1;
  logic       refill;
  logic [2:0] refill_p;
  logic       motor;
  logic [2:0] motor_p;
  logic       coin_ret;
  logic [1:0] done;
  logic [1:0] nack;
  logic       busy;
  logic [7:0] empty;

  // Scheduler side
  modport slave (
    input  req, p0, p1, chg0, chg1, paid0, paid1, refill, refill_p,
    output motor, motor_p, coin_ret, done, nack, busy, empty
  );

  // Panel cores / environment side
  modport master (
    output req, p0, p1, chg0, chg1, paid0, paid1, refill, refill_p,
    input  motor, motor_p, coin_ret, done, nack, busy, empty
  );
endinterface

// File: rtl/vend_dispense_scheduler.sv
// Round-robin scheduler sharing one dispense motor and one coin-return unit
// between two vending panels, with per-product stock tracking.
module vend_dispense_scheduler #(
  parameter int unsigned DISP_CYCLES = 4,
  parameter int unsigned STOCK_INIT  = 3
) (
  input logic                        clk,
  input logic                        rst,
  vend_dispense_scheduler_if.slave   bus
);
  localparam int unsigned NPROD = 8;
  localparam int unsigned SW    = 4;
  localparam int unsigned PW    = 3;

  typedef enum logic [2:0] {IDLE, CHECK, DISPENSE, PAYOUT, FINISH} state_t;

  state_t                      state, state_nxt;
  logic                        last, last_nxt;
  logic                        gnt, gnt_nxt;
  logic [PW-1:0]               prod, prod_nxt;
  logic [PW-1:0]               chg, chg_nxt;
  logic [PW-1:0]               paid, paid_nxt;
  logic                        ok, ok_nxt;
  logic [SW-1:0]               timer, timer_nxt;
  logic [PW-1:0]               cnt, cnt_nxt;
  logic                        dec_c;
  logic [NPROD-1:0][SW-1:0]    stock;
  logic [NPROD-1:0]            empty_c;

  logic                        motor_q;
  logic [PW-1:0]               motor_p_q;
  logic                        coin_ret_q;
  logic [1:0]                  done_q;
  logic [1:0]                  nack_q;
  logic                        busy_q;

  // State, latched request and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last       <= 1'b1;
      gnt        <= 1'b0;
      prod       <= '0;
      chg        <= '0;
      paid       <= '0;
      ok         <= 1'b0;
      timer      <= '0;
      cnt        <= '0;
      motor_q    <= 1'b0;
      motor_p_q  <= '0;
      coin_ret_q <= 1'b0;
      done_q     <= '0;
      nack_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      last       <= last_nxt;
      gnt        <= gnt_nxt;
      prod       <= prod_nxt;
      chg        <= chg_nxt;
      paid       <= paid_nxt;
      ok         <= ok_nxt;
      timer      <= timer_nxt;
      cnt        <= cnt_nxt;
      motor_q    <= (state_nxt == DISPENSE);
      motor_p_q  <= (state_nxt == DISPENSE) ? prod_nxt : '0;
      coin_ret_q <= (state_nxt == PAYOUT) && (cnt_nxt != '0);
      done_q     <= (state_nxt == FINISH && ok_nxt)  ? {gnt_nxt, !gnt_nxt} : 2'b00;
      nack_q     <= (state_nxt == FINISH && !ok_nxt) ? {gnt_nxt, !gnt_nxt} : 2'b00;
      busy_q     <= (state_nxt != IDLE);
    end
  end

  // Next-state: arbitration, stock check, motor timing and coin payout
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    gnt_nxt   = gnt;
    prod_nxt  = prod;
    chg_nxt   = chg;
    paid_nxt  = paid;
    ok_nxt    = ok;
    timer_nxt = timer;
    cnt_nxt   = cnt;
    dec_c     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req != 2'b00) begin
          // On a tie the panel not served last wins; a lone request wins outright.
          gnt_nxt   = (bus.req == 2'b11) ? !last : bus.req[1];
          prod_nxt  = gnt_nxt ? bus.p1    : bus.p0;
          chg_nxt   = gnt_nxt ? bus.chg1  : bus.chg0;
          paid_nxt  = gnt_nxt ? bus.paid1 : bus.paid0;
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (stock[prod] == '0) begin
          ok_nxt    = 1'b0;
          cnt_nxt   = paid;
          state_nxt = PAYOUT;
        end else begin
          ok_nxt    = 1'b1;
          dec_c     = 1'b1;
          timer_nxt = SW'(DISP_CYCLES);
          state_nxt = DISPENSE;
        end
      end
      DISPENSE: begin
        timer_nxt = timer - SW'(1);
        if (timer == SW'(1)) begin
          cnt_nxt   = chg;
          state_nxt = PAYOUT;
        end
      end
      PAYOUT: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - PW'(1);
        end else begin
          state_nxt = FINISH;
        end
      end
      FINISH: begin
        last_nxt  = gnt;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stock counters: saturating refill, decrement on dispense, simultaneous hits cancel
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NPROD); i++) stock[i] <= SW'(STOCK_INIT);
    end else begin
      for (int i = 0; i < int'(NPROD); i++) begin
        if (bus.refill && bus.refill_p == PW'(i) && !(dec_c && prod == PW'(i))) begin
          if (stock[i] != {SW{1'b1}}) stock[i] <= stock[i] + SW'(1);
        end else if (dec_c && prod == PW'(i) && !(bus.refill && bus.refill_p == PW'(i))) begin
          stock[i] <= stock[i] - SW'(1);
        end
      end
    end
  end

  // Out-of-stock flags decoded from the counters
  always_comb begin
    empty_c = '0;
    for (int i = 0; i < int'(NPROD); i++) empty_c[i] = (stock[i] == '0);
  end

  assign bus.motor    = motor_q;
  assign bus.motor_p  = motor_p_q;
  assign bus.coin_ret = coin_ret_q;
  assign bus.done     = done_q;
  assign bus.nack     = nack_q;
  assign bus.busy     = busy_q;
  assign bus.empty    = empty_c;
endmodule

// File: tb/tb_vend_dispense_scheduler.sv
// Directed bench for vend_dispense_scheduler: reset, vend, reject, arbitration,
// refill and mid-dispense reset.
module tb_vend_dispense_scheduler;
  localparam int D = 4;

  logic clk;
  logic rst;
  int   passed;
  int   total;

  vend_dispense_scheduler_if bus ();

  vend_dispense_scheduler #(.DISP_CYCLES(D), .STOCK_INIT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Serve one request starting from the IDLE cycle that samples it; checks every cycle.
  task automatic serve(input int g, input logic [2:0] prod, input int chg, input int paid,
                       input logic ok, input logic refill_chk);
    int  last_k;
    logic mot, coin, fin;
    last_k = ok ? 3 + D + chg : 3 + paid;
    chk("idle_busy", 32'(bus.busy), 0);
    for (int k = 1; k <= last_k; k++) begin
      tick();
      if (refill_chk) begin
        if (k == 1) begin bus.refill = 1'b1; bus.refill_p = prod; end
        else bus.refill = 1'b0;
      end
      mot  = ok && k >= 2 && k <= 1 + D;
      coin = ok ? (k >= 2 + D && k <= 1 + D + chg) : (k >= 2 && k <= 1 + paid);
      fin  = (k == last_k);
      chk($sformatf("motor_k%0d", k),    32'(bus.motor),    32'(mot));
      chk($sformatf("motor_p_k%0d", k),  32'(bus.motor_p),  mot ? 32'(prod) : 0);
      chk($sformatf("coin_ret_k%0d", k), 32'(bus.coin_ret), 32'(coin));
      chk($sformatf("done_k%0d", k),     32'(bus.done),     (fin && ok)  ? 32'(1 << g) : 0);
      chk($sformatf("nack_k%0d", k),     32'(bus.nack),     (fin && !ok) ? 32'(1 << g) : 0);
      chk($sformatf("busy_k%0d", k),     32'(bus.busy),     1);
    end
    bus.req[g] = 1'b0;
    tick();
    chk("post_busy", 32'(bus.busy), 0);
    chk("post_done", 32'(bus.done), 0);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_motor"},   32'(bus.motor),    0);
    chk({tag, "_motor_p"}, 32'(bus.motor_p),  0);
    chk({tag, "_coin"},    32'(bus.coin_ret), 0);
    chk({tag, "_done"},    32'(bus.done),     0);
    chk({tag, "_nack"},    32'(bus.nack),     0);
    chk({tag, "_busy"},    32'(bus.busy),     0);
    chk({tag, "_empty"},   32'(bus.empty),    0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    check_quiet("rst");
    tick();
    rst = 1'b1;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst = 1'b0;
    bus.req = '0; bus.p0 = '0; bus.p1 = '0; bus.chg0 = '0; bus.chg1 = '0;
    bus.paid0 = '0; bus.paid1 = '0; bus.refill = 1'b0; bus.refill_p = '0;

    // Reset and idle
    tick();
    do_reset();
    repeat (5) tick();
    check_quiet("idle");

    // Single vend, panel 0, product 2, two change units
    bus.p0 = 3'd2; bus.chg0 = 3'd2; bus.paid0 = 3'd3; bus.req[0] = 1'b1;
    serve(0, 3'd2, 2, 3, 1'b1, 1'b0);
    chk("stock2_after_vend", 32'(dut.stock[2]), 2);

    // Drain product 5, then a rejected request refunds paid
    bus.p0 = 3'd5; bus.chg0 = 3'd0; bus.paid0 = 3'd1;
    for (int n = 0; n < 3; n++) begin
      bus.req[0] = 1'b1;
      serve(0, 3'd5, 0, 1, 1'b1, 1'b0);
    end
    chk("empty5", 32'(bus.empty), 32'h20);
    bus.paid0 = 3'd3; bus.req[0] = 1'b1;
    serve(0, 3'd5, 0, 3, 1'b0, 1'b0);
    chk("stock5_reject", 32'(dut.stock[5]), 0);

    // Refill an empty product
    bus.refill = 1'b1; bus.refill_p = 3'd5;
    tick();
    bus.refill = 1'b0;
    chk("empty_after_refill", 32'(bus.empty), 0);
    chk("stock5_refill", 32'(dut.stock[5]), 1);

    // Refill coinciding with the dispense decrement leaves stock unchanged
    bus.p0 = 3'd2; bus.chg0 = 3'd1; bus.req[0] = 1'b1;
    serve(0, 3'd2, 1, 3, 1'b1, 1'b1);
    chk("stock2_refill_dec", 32'(dut.stock[2]), 2);

    // Saturating refill
    bus.refill = 1'b1; bus.refill_p = 3'd3;
    repeat (14) tick();
    bus.refill = 1'b0;
    chk("stock3_sat", 32'(dut.stock[3]), 15);

    // Arbitration after reset: panel 0 first, then panel 1, then panel 0 again
    do_reset();
    tick();
    bus.p0 = 3'd1; bus.chg0 = 3'd1; bus.paid0 = 3'd0;
    bus.p1 = 3'd4; bus.chg1 = 3'd0; bus.paid1 = 3'd2;
    bus.req = 2'b11;
    serve(0, 3'd1, 1, 0, 1'b1, 1'b0);
    serve(1, 3'd4, 0, 2, 1'b1, 1'b0);
    bus.req = 2'b11;
    serve(0, 3'd1, 1, 0, 1'b1, 1'b0);
    serve(1, 3'd4, 0, 2, 1'b1, 1'b0);
    chk("stock1_arb", 32'(dut.stock[1]), 1);
    chk("stock4_arb", 32'(dut.stock[4]), 1);

    // Reset during the second motor cycle
    bus.p0 = 3'd6; bus.chg0 = 3'd2; bus.req[0] = 1'b1;
    tick();
    tick();
    tick();
    chk("mid_motor_on", 32'(bus.motor), 1);
    chk("mid_stock6_dec", 32'(dut.stock[6]), 2);
    rst = 1'b0;
    #1;
    chk("mid_motor_off", 32'(bus.motor), 0);
    chk("mid_busy", 32'(bus.busy), 0);
    chk("mid_coin", 32'(bus.coin_ret), 0);
    chk("mid_stock6_restored", 32'(dut.stock[6]), 3);
    bus.req = 2'b00;
    tick();
    chk("mid_no_done", 32'(bus.done), 0);
    rst = 1'b1;
    repeat (8) begin
      tick();
      chk("post_rst_done", 32'(bus.done), 0);
      chk("post_rst_busy", 32'(bus.busy), 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
